grant_logic: RTL and testbench
==============================

GRANT_LOGIC -- requirements
Module: grant_logic

Interface
REQ-001 Parameters: none; all widths are fixed.
REQ-002 Clock  input  1  single clock; all state changes on rising edge.
REQ-003 Resetn  input  1  asynchronous, active-low reset.
REQ-004 i_request  input  [3:0]  bus requests.
  - i_request[k], k=1..3: requester k wants the bus.
  - i_request[0]: reserved and ignored by all logic.
REQ-005 o_grant  output  [1:3]  registered one-hot bus grant.
  - o_grant[k] = 1: requester k owns the bus.
  - Vector order [1:3] makes o_grant[1] the MSB; a grant to requester 1 reads 3'b100.
REQ-006 One clock and one reset; reset is asynchronous and active-low; ports are named Clock and Resetn.

Function
REQ-007 The block SHALL be a Moore FSM with states IDLE, G1, G2, G3, plus a 2-bit last-served pointer LAST (values 1..3).
REQ-008 o_grant SHALL decode from state only:
  - IDLE = 000, G1 = 100, G2 = 010, G3 = 001.
  - At most one grant bit is ever high.
REQ-009 Request bits SHALL be sampled at each rising edge; a grant change appears one clock after the request pattern that causes it (latency 1 cycle).
REQ-010 IDLE with no request among bits 1..3 SHALL remain IDLE.
REQ-011 IDLE with one or more requests SHALL move to Gk, where k is the first requester found round-robin starting at LAST+1 (wrapping 3 -> 1).
REQ-012 In Gk with i_request[k]=1, the FSM SHALL stay in Gk; no pre-emption by any other requester at any priority.
REQ-013 In Gk with i_request[k]=0 at the edge:
  - LAST SHALL be set to k.
  - The FSM SHALL move directly to the next requesting j != k, searched round-robin from k+1; otherwise to IDLE.
  - There is no idle bubble when another request is pending.
REQ-014 LAST SHALL update only when a grant is released; entering Gk does not change it.
REQ-015 Simultaneous requests SHALL be resolved solely by REQ-011/REQ-013. With LAST=3, priority order is 1 > 2 > 3.
REQ-016 A request that drops and re-asserts while ungranted SHALL receive no preferential treatment.
REQ-017 i_request[0] SHALL have no effect on state, LAST or o_grant in any state.
REQ-018 No combinational path SHALL exist from i_request to o_grant.

Reset
REQ-019 Resetn=0 SHALL immediately (asynchronously) force:
  - state to IDLE, o_grant to 000 and LAST to 3;
  - this holds independent of Clock and i_request.
REQ-020 While Resetn=0, state and outputs SHALL hold their reset values regardless of Clock edges.
REQ-021 Reset asserted mid-grant SHALL drop the grant at once.
REQ-022 After Resetn rises, arbitration SHALL resume at the next rising edge with priority 1 > 2 > 3.

Verification
REQ-023 Resetn=0, i_request=0000 for 5 clocks -> o_grant=000 throughout.
REQ-024 Release reset and set i_request=0010 -> o_grant=100 after the first rising edge; held for 5 clocks while the request stays high.
REQ-025 Resetn=0 while in G1 -> o_grant=000 immediately, without waiting for an edge. Release reset with i_request=0010 -> o_grant=100 one edge later.
REQ-026 Round-robin handover:
  - i_request=1110 from IDLE after reset -> 100.
  - Drop bit 1 (i_request=1100) -> 010 next edge.
  - Drop bit 2 -> 001.
  - Drop bit 3 with bit 1 re-raised -> 100.
  - Drop all -> 000.
REQ-027 i_request=0001 only, any state sequence -> o_grant stays 000.
REQ-028 Random request stimulus, 1000+ cycles, checked against a reference model:
  - o_grant is one-hot or zero on every cycle;
  - each grant is held until its own request drops;
  - no requester that is continuously requesting waits more than two other grants.

Source files
------------

// File: rtl/grant_logic.sv
// Three-requester round-robin bus arbiter. A grant is held until its owner
// releases it; the next owner is searched for starting after the last one served.
module grant_logic (
    input  logic       Clock,
    input  logic       Resetn,
    input  logic [3:0] i_request,
    output logic [1:3] o_grant
);

    // The encoding doubles as the owner's requester number (G1 = 1, ...).
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        G1   = 2'd1,
        G2   = 2'd2,
        G3   = 2'd3
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [1:0] last;
    logic [1:0] last_next;
    logic [1:0] owner;
    logic [3:0] req;
    logic       unused_req0;

    // Bit 0 is a reserved slot; masking it means it can never be picked.
    assign req         = {i_request[3:1], 1'b0};
    assign unused_req0 = i_request[0];
    assign owner       = state;

    // First requester found round-robin strictly after 'from', or 0 if none.
    function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] from);
        logic [1:0] cand;
        logic [1:0] pick;
        cand = from;
        pick = 2'd0;
        for (int i = 0; i < 3; i++) begin
            cand = (cand == 2'd3) ? 2'd1 : cand + 2'd1;
            if (pick == 2'd0 && r[cand]) begin
                pick = cand;
            end
        end
        return pick;
    endfunction

    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_next = state;
        last_next  = last;
        if (state == IDLE) begin
            state_next = state_t'(rr_pick(req, last));
        end else if (!req[owner]) begin
            // Release: hand over directly, no idle bubble between owners.
            last_next  = owner;
            state_next = state_t'(rr_pick(req, owner));
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state <= IDLE;
            last  <= 2'd3;
        end else begin
            state <= state_next;
            last  <= last_next;
        end
    end

    // Moore decode: the grant depends on the state register only.
    always_comb begin
        o_grant = 3'b000;
        case (state)
            G1:      o_grant = 3'b100;
            G2:      o_grant = 3'b010;
            G3:      o_grant = 3'b001;
            default: o_grant = 3'b000;
        endcase
    end

endmodule

// File: tb/tb_grant_logic.sv
// Self-checking bench for grant_logic: directed scenarios plus randomized
// requests compared against a behavioural round-robin owner/last model.
module tb_grant_logic;

    logic       Clock;
    logic       Resetn;
    logic [3:0] i_request;
    logic [1:3] o_grant;

    int errors = 0;
    int checks = 0;

    // Reference model: current owner (0 = nobody) and last requester served.
    int m_owner;
    int m_last;

    grant_logic dut (
        .Clock     (Clock),
        .Resetn    (Resetn),
        .i_request (i_request),
        .o_grant   (o_grant)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    function automatic logic [1:3] grant_of(input int owner);
        logic [1:3] g;
        g = 3'b000;
        if (owner >= 1 && owner <= 3) g[owner] = 1'b1;
        return g;
    endfunction

    task automatic model_reset();
        m_owner = 0;
        m_last  = 3;
    endtask

    // Apply the round-robin rules to the request pattern seen at one edge.
    task automatic model_step(input logic [3:0] r);
        int start;
        int c;
        if (m_owner != 0 && r[m_owner]) return;
        start = m_last;
        if (m_owner != 0) begin
            m_last = m_owner;
            start  = m_owner;
        end
        m_owner = 0;
        for (int i = 1; i <= 3; i++) begin
            c = (start + i - 1) % 3 + 1;
            if (m_owner == 0 && r[c]) m_owner = c;
        end
    endtask

    // Drive a pattern, advance one rising edge, sample 1 time unit later.
    task automatic cycle(input logic [3:0] r);
        i_request = r;
        if (Resetn) model_step(r);
        @(posedge Clock);
        #1;
    endtask

    task automatic expect_grant(input string name, input logic [1:3] exp);
        checks++;
        if (o_grant !== exp) begin
            errors++;
            $display("FAIL %s: o_grant=%b expected=%b at %0t", name, o_grant, exp, $time);
        end
    endtask

    task automatic apply_reset();
        Resetn = 1'b0;
        model_reset();
        cycle(4'b0000);
        Resetn = 1'b1;
    endtask

    task automatic test_reset();
        Resetn    = 1'b0;
        i_request = 4'b0000;
        model_reset();
        #1;
        expect_grant("reset_async_start", 3'b000);
        for (int i = 0; i < 5; i++) begin
            cycle(4'b0000);
            expect_grant("reset_idle_hold", 3'b000);
        end
        // Clock edges with requests present must not disturb reset.
        for (int i = 0; i < 3; i++) begin
            cycle(4'b1110);
            expect_grant("reset_ignores_req", 3'b000);
        end
    endtask

    task automatic test_first_grant();
        Resetn = 1'b1;
        cycle(4'b0010);
        expect_grant("first_grant", 3'b100);
        for (int i = 0; i < 5; i++) begin
            cycle(4'b0010);
            expect_grant("first_grant_hold", 3'b100);
        end
    endtask

    task automatic test_async_reset();
        // Currently in G1; assert reset between edges.
        #2;
        Resetn = 1'b0;
        model_reset();
        #1;
        expect_grant("async_drop_no_edge", 3'b000);
        cycle(4'b0010);
        expect_grant("async_held_over_edge", 3'b000);
        Resetn = 1'b1;
        cycle(4'b0010);
        expect_grant("async_resume", 3'b100);
    endtask

    task automatic test_round_robin();
        logic [3:0] pats [5];
        logic [1:3] exps [5];
        pats = '{4'b1110, 4'b1100, 4'b1000, 4'b0010, 4'b0000};
        exps = '{3'b100, 3'b010, 3'b001, 3'b100, 3'b000};
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            cycle(pats[i]);
            expect_grant($sformatf("rr_handover_%0d", i), exps[i]);
        end
        // LAST is now 1, so simultaneous requests go to 2 first.
        cycle(4'b1110);
        expect_grant("rr_after_last1", 3'b010);
        cycle(4'b0000);
        expect_grant("rr_release_idle", 3'b000);
    endtask

    task automatic test_reserved_bit();
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            cycle(4'b0001);
            expect_grant("reserved_only", 3'b000);
        end
        cycle(4'b0100);
        expect_grant("reserved_g2_enter", 3'b010);
        cycle(4'b0101);
        expect_grant("reserved_g2_hold", 3'b010);
        cycle(4'b0001);
        expect_grant("reserved_g2_release", 3'b000);
    endtask

    task automatic test_random();
        logic [3:0] r;
        logic [3:0] prev_r;
        logic [1:3] prev_g;
        int         waits [1:3];
        int         new_owner;
        int         prev_owner;
        apply_reset();
        r = 4'b0000;
        prev_g = 3'b000;
        for (int k = 1; k <= 3; k++) waits[k] = 0;
        for (int n = 0; n < 1500; n++) begin
            prev_r = r;
            for (int k = 1; k <= 3; k++) begin
                if ($urandom_range(99) < 30) r[k] = ~r[k];
            end
            r[0] = 1'($urandom_range(1));
            cycle(r);

            expect_grant("rand_model", grant_of(m_owner));

            checks++;
            if ($countones(o_grant) > 1) begin
                errors++;
                $display("FAIL rand_onehot: o_grant=%b expected at most one bit", o_grant);
            end

            prev_owner = 0;
            new_owner  = 0;
            for (int k = 1; k <= 3; k++) begin
                if (prev_g[k]) prev_owner = k;
                if (o_grant[k]) new_owner = k;
            end
            if (prev_owner != 0 && r[prev_owner]) begin
                checks++;
                if (o_grant !== prev_g) begin
                    errors++;
                    $display("FAIL rand_hold: o_grant=%b expected=%b", o_grant, prev_g);
                end
            end

            for (int k = 1; k <= 3; k++) begin
                if (!r[k] || new_owner == k) begin
                    waits[k] = 0;
                end else if (new_owner != 0 && new_owner != prev_owner) begin
                    waits[k]++;
                    checks++;
                    if (waits[k] > 2) begin
                        errors++;
                        $display("FAIL rand_fairness: requester %0d waited %0d grants, expected <= 2",
                                 k, waits[k]);
                    end
                end
            end
            prev_g = o_grant;
        end
        // prev_r keeps the last two patterns visible when debugging.
        if (prev_r === 4'bxxxx) $display("note: undefined request history");
    endtask

    initial begin
        Resetn    = 1'b0;
        i_request = 4'b0000;
        model_reset();
        test_reset();
        test_first_grant();
        test_async_reset();
        test_round_robin();
        test_reserved_bit();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Backstop so the run always ends on its own.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion before 200000");
        $fatal(1);
    end

endmodule
